// File: rtl/systolic_feeder.sv
// Purpose : host-side sequencer for the 4x4 systolic array (load weights/inputs, capture results, drain).
// Latency : accepted load beat appears on arr_* one cycle later; result channel 0 offered the cycle after capture.
// Backpres: s_ready only in load states (host may stall freely); drain holds m_data/m_index while m_ready is low.
//
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   start, keep_weights        transaction request (IDLE only); keep_weights=1 skips the weight phase
//   s_valid/s_ready/s_data     host load-word stream (DATA_W bits per beat)
//   arr_data, arr_load_*       replayed load word and its one-cycle weight/input strobe
//   arr_results, arr_valid     array result bus (channel k at [k*RES_W +: RES_W]) and its valid pulse
//   m_valid/m_ready/m_data     result stream back to the host, one channel per handshake
//   m_index, m_last            channel number of m_data, high on channel N-1
//   busy, done, timeout_err    status: not idle, one-cycle completion pulse, sticky abort flag
module systolic_feeder #(
    parameter int DATA_W  = 4,
    parameter int N       = 4,
    parameter int RES_W   = 8,
    parameter int TIMEOUT = 31      // cycles allowed in WAIT; expected to be >= 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     keep_weights,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_W-1:0]        s_data,
    output logic [DATA_W-1:0]        arr_data,
    output logic                     arr_load_weights,
    output logic                     arr_load_inputs,
    input  logic [N*RES_W-1:0]       arr_results,
    input  logic                     arr_valid,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [RES_W-1:0]         m_data,
    output logic [$clog2(N)-1:0]     m_index,
    output logic                     m_last,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout_err
);

    localparam int IDX_W = $clog2(N);
    // One spare bit so a phase counter can never wrap back to 0 inside a phase.
    localparam int CNT_W = $clog2(N) + 1;
    localparam int TO_W  = $clog2(TIMEOUT);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(N - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_LOAD_X = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DRAIN  = 3'd4
    } state_e;

    state_e             state_q,    state_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]   idx_q,      idx_d;
    logic [TO_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0]  arr_data_q, arr_data_d;
    logic               ld_w_q,     ld_w_d;
    logic               ld_x_q,     ld_x_d;
    logic               done_q,     done_d;
    logic               err_q,      err_d;
    logic [RES_W-1:0]   snap_q [N];
    logic [RES_W-1:0]   snap_d [N];

    logic               in_load;
    logic               beat_acc;

    assign in_load  = (state_q == ST_LOAD_W) || (state_q == ST_LOAD_X);
    assign beat_acc = s_valid && in_load;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        idx_d      = idx_q;
        wait_cnt_d = wait_cnt_q;
        arr_data_d = arr_data_q;      // word holds when no strobe fires
        ld_w_d     = 1'b0;
        ld_x_d     = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;
        snap_d     = snap_q;

        case (state_q)
            ST_IDLE: begin
                // keep_weights is captured by the choice of first load state.
                if (start) begin
                    err_d      = 1'b0;
                    beat_cnt_d = '0;
                    state_d    = keep_weights ? ST_LOAD_X : ST_LOAD_W;
                end
            end

            ST_LOAD_W, ST_LOAD_X: begin
                if (beat_acc) begin
                    arr_data_d = s_data;
                    ld_w_d     = (state_q == ST_LOAD_W);
                    ld_x_d     = (state_q == ST_LOAD_X);
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_d = '0;
                        wait_cnt_d = '0;
                        state_d    = (state_q == ST_LOAD_W) ? ST_LOAD_X : ST_WAIT;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_WAIT: begin
                // WAIT lasts at most TIMEOUT cycles (counter 0..TIMEOUT-1).
                // A valid pulse in the final cycle still wins over the abort.
                if (arr_valid) begin
                    for (int k = 0; k < N; k++) begin
                        snap_d[k] = arr_results[k*RES_W +: RES_W];
                    end
                    idx_d   = '0;
                    state_d = ST_DRAIN;
                end else if (wait_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + TO_W'(1);
                end
            end

            ST_DRAIN: begin
                if (m_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
            idx_q      <= '0;
            wait_cnt_q <= '0;
            arr_data_q <= '0;
            ld_w_q     <= 1'b0;
            ld_x_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            snap_q     <= '{default: '0};
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            idx_q      <= idx_d;
            wait_cnt_q <= wait_cnt_d;
            arr_data_q <= arr_data_d;
            ld_w_q     <= ld_w_d;
            ld_x_q     <= ld_x_d;
            done_q     <= done_d;
            err_q      <= err_d;
            snap_q     <= snap_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all decoded directly from registers)
    // ------------------------------------------------------------------
    assign s_ready          = in_load;
    assign arr_data         = arr_data_q;
    assign arr_load_weights = ld_w_q;
    assign arr_load_inputs  = ld_x_q;
    assign m_valid          = (state_q == ST_DRAIN);
    // idx_q only changes on a handshake, so m_data/m_index are stable under stall.
    assign m_data           = snap_q[idx_q[IDX_W-1:0]];
    assign m_index          = idx_q[IDX_W-1:0];
    assign m_last           = (state_q == ST_DRAIN) && (idx_q == LAST_IDX);
    assign busy             = (state_q != ST_IDLE);
    assign done             = done_q;
    assign timeout_err      = err_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Purpose : randomized self-checking bench for systolic_feeder against a transaction-level model.
// Latency : model expects strobes one cycle after each accepted beat and result 0 one cycle after capture.
// Backpres: bench drives s_valid and m_ready stalls (fixed, toggled or random) and checks stability.
module tb_systolic_feeder;

    localparam int DATA_W  = 4;
    localparam int N       = 4;
    localparam int RES_W   = 8;
    localparam int TIMEOUT = 31;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  start = 1'b0;
    logic                  keep_weights = 1'b0;
    logic                  s_valid = 1'b0;
    logic                  s_ready;
    logic [DATA_W-1:0]     s_data = '0;
    logic [DATA_W-1:0]     arr_data;
    logic                  arr_load_weights;
    logic                  arr_load_inputs;
    logic [N*RES_W-1:0]    arr_results = '0;
    logic                  arr_valid = 1'b0;
    logic                  m_valid;
    logic                  m_ready = 1'b0;
    logic [RES_W-1:0]      m_data;
    logic [$clog2(N)-1:0]  m_index;
    logic                  m_last;
    logic                  busy;
    logic                  done;
    logic                  timeout_err;

    systolic_feeder #(
        .DATA_W(DATA_W), .N(N), .RES_W(RES_W), .TIMEOUT(TIMEOUT)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .keep_weights(keep_weights),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .arr_data(arr_data), .arr_load_weights(arr_load_weights), .arr_load_inputs(arr_load_inputs),
        .arr_results(arr_results), .arr_valid(arr_valid),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index), .m_last(m_last),
        .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Transaction model state
    logic [DATA_W-1:0] beats [2*N];   // words the host sends, in order
    logic [RES_W-1:0]  res   [N];     // what the array presents on its valid pulse
    logic [DATA_W-1:0] mdl_data = '0; // last word replayed to the array
    bit                mdl_err  = 1'b0;
    bit                cur_keep = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N*RES_W-1:0] pack_res();
        logic [N*RES_W-1:0] v;
        for (int k = 0; k < N; k++) v[k*RES_W +: RES_W] = res[k];
        return v;
    endfunction

    // Expected strobe/data for the cycle after a (possibly) accepted beat:
    // beat numbers 0..N-1 are weights unless weights are kept, the rest are inputs.
    task automatic check_load(input bit pend, input int idx);
        bit ew, ex;
        ew = pend && !cur_keep && (idx < N);
        ex = pend && !ew;
        if (pend) mdl_data = beats[idx];
        check("ld_w", arr_load_weights, ew);
        check("ld_x", arr_load_inputs, ex);
        check("arr_data", arr_data, mdl_data);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_s_ready"}, s_ready, 0);
        check({tag, "_arr_data"}, arr_data, 0);
        check({tag, "_ld_w"}, arr_load_weights, 0);
        check({tag, "_ld_x"}, arr_load_inputs, 0);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_data"}, m_data, 0);
        check({tag, "_m_index"}, m_index, 0);
        check({tag, "_m_last"}, m_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, timeout_err, 0);
    endtask

    // s_mode: 0 back-to-back, 1 toggled valid, 2 random valid + arr_valid noise
    // m_mode: 0 always ready, 1 five-cycle stall on channel 2, 2 random ready
    // vlat  : WAIT cycle (0-based) in which arr_valid pulses; <0 or >=TIMEOUT means never in WAIT
    task automatic run_txn(input bit keep, input int s_mode, input int m_mode, input int vlat);
        int nb, acc, pend_idx, g, idx, stall;
        bit pend, captured;
        nb = keep ? N : 2*N;
        cur_keep = keep;

        @(posedge clk); #1;
        start = 1'b1; keep_weights = keep; s_valid = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_err", timeout_err, mdl_err);

        acc = 0; pend = 1'b0; pend_idx = 0; g = 0;
        while (acc < nb) begin
            @(posedge clk); #1;
            start = 1'b0;
            keep_weights = 1'($urandom_range(0, 1));
            case (s_mode)
                0:       s_valid = 1'b1;
                1:       s_valid = (g % 2 == 0);
                default: s_valid = 1'($urandom_range(0, 1));
            endcase
            s_data      = beats[acc];
            arr_valid   = (s_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            arr_results = (N*RES_W)'($urandom);
            @(negedge clk);
            mdl_err = 1'b0;
            check("ld_busy", busy, 1);
            check("ld_s_ready", s_ready, 1);
            check("ld_err", timeout_err, mdl_err);
            check("ld_m_valid", m_valid, 0);
            check_load(pend, pend_idx);
            pend = s_valid; pend_idx = acc;
            if (s_valid) acc++;
            g++;
            if (g > 200) begin
                check("ld_guard", acc, nb);
                break;
            end
        end

        captured = 1'b0;
        for (int k = 0; k < TIMEOUT; k++) begin
            @(posedge clk); #1;
            s_valid     = 1'b1;               // extra words must not be taken
            s_data      = DATA_W'($urandom);
            arr_valid   = (k == vlat);
            arr_results = (k == vlat) ? pack_res() : (N*RES_W)'($urandom);
            @(negedge clk);
            check_load((k == 0) && pend, pend_idx);
            check("wt_s_ready", s_ready, 0);
            check("wt_busy", busy, 1);
            check("wt_m_valid", m_valid, 0);
            check("wt_err", timeout_err, 0);
            if (k == vlat) begin
                captured = 1'b1;
                break;
            end
        end

        if (!captured) begin
            // Abort exactly TIMEOUT cycles after entering WAIT; late valid pulses ignored.
            for (int k = 0; k < 3; k++) begin
                @(posedge clk); #1;
                s_valid = 1'b0; arr_valid = 1'b1; arr_results = (N*RES_W)'($urandom);
                @(negedge clk);
                check("to_busy", busy, 0);
                check("to_err", timeout_err, 1);
                check("to_m_valid", m_valid, 0);
                check("to_done", done, 0);
                check("to_s_ready", s_ready, 0);
            end
            arr_valid = 1'b0;
            mdl_err = 1'b1;
        end else begin
            idx = 0; g = 0; stall = 0;
            while (idx < N && g < 100) begin
                @(posedge clk); #1;
                s_valid      = 1'b0;
                arr_valid    = 1'($urandom_range(0, 1));
                arr_results  = (N*RES_W)'($urandom);
                start        = 1'($urandom_range(0, 1));   // must be ignored
                keep_weights = 1'($urandom_range(0, 1));
                case (m_mode)
                    0: m_ready = 1'b1;
                    1: begin
                        if (idx == 2 && stall < 5) begin
                            m_ready = 1'b0; stall++;
                        end else begin
                            m_ready = 1'b1;
                        end
                    end
                    default: m_ready = 1'($urandom_range(0, 1));
                endcase
                @(negedge clk);
                check("dr_m_valid", m_valid, 1);
                check("dr_m_index", m_index, idx);
                check("dr_m_data", m_data, res[idx]);
                check("dr_m_last", m_last, idx == N-1);
                check("dr_busy", busy, 1);
                check("dr_done", done, 0);
                check_load(1'b0, 0);
                if (m_ready) idx++;
                g++;
            end
            check("dr_count", idx, N);
            @(posedge clk); #1;
            start = 1'b0; m_ready = 1'b0; arr_valid = 1'b0;
            @(negedge clk);
            check("done_pulse", done, 1);
            check("end_busy", busy, 0);
            check("end_m_valid", m_valid, 0);
            check("end_err", timeout_err, 0);
            @(posedge clk); #1;
            @(negedge clk);
            check("done_once", done, 0);
            check("end_idle", busy, 0);
        end
    endtask

    task automatic reset_mid_load();
        cur_keep = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; keep_weights = 1'b1;
        for (int b = 0; b < 2; b++) begin
            @(posedge clk); #1;
            start = 1'b0; s_valid = 1'b1; s_data = DATA_W'(b + 3);
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("pre_rst_ld_x", arr_load_inputs, 1);
        check("pre_rst_data", arr_data, 4);
        check("pre_rst_busy", busy, 1);
        #1 reset_n = 1'b0;
        #1 check_zero("rst_mid");
        s_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        mdl_data = '0; mdl_err = 1'b0;
        check_zero("rst_rel");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        int vlat, r;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Full transaction with known words and results.
        for (int i = 0; i < 2*N; i++) beats[i] = DATA_W'(i + 1);
        res[0] = 8'h11; res[1] = 8'h22; res[2] = 8'h33; res[3] = 8'h44;
        run_txn(1'b0, 0, 0, 4);

        // Keep weights: inputs only.
        for (int i = 0; i < N; i++) beats[i] = DATA_W'(i + 9);
        for (int k = 0; k < N; k++) res[k] = RES_W'($urandom);
        run_txn(1'b1, 0, 0, $urandom_range(0, 10));

        // Toggled s_valid and a stall on channel 2 (0x33 held).
        for (int i = 0; i < 2*N; i++) beats[i] = DATA_W'($urandom);
        res[0] = 8'h11; res[1] = 8'h22; res[2] = 8'h33; res[3] = 8'h44;
        run_txn(1'b0, 1, 1, 2);

        // Timeout, then capture in the last legal WAIT cycle (clears the flag).
        run_txn(1'b0, 0, 0, -1);
        for (int k = 0; k < N; k++) res[k] = RES_W'($urandom);
        run_txn(1'b1, 2, 0, TIMEOUT - 1);

        // Timeout again so a reset must clear the sticky flag, then reset mid LOAD_X.
        run_txn(1'b1, 0, 0, TIMEOUT);
        reset_mid_load();

        // Random transactions.
        for (int t = 0; t < 14; t++) begin
            for (int i = 0; i < 2*N; i++) beats[i] = DATA_W'($urandom);
            for (int k = 0; k < N; k++) res[k] = RES_W'($urandom);
            r = $urandom_range(0, 9);
            if (r == 0)      vlat = -1;
            else if (r == 1) vlat = TIMEOUT;
            else             vlat = $urandom_range(0, TIMEOUT - 1);
            run_txn(1'($urandom_range(0, 1)), 2, 2, vlat);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
